fifo_flagged: RTL and testbench
===============================

# fifo_flagged

Parametrised synchronous FIFO: the next-generation buffer for processor-side queues (fetch, store, I/O). It adds occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, and overflow/underflow pulses. It also defines the behaviour of simultaneous read/write at the empty and full boundaries. Storage is a register-file array with a combinational read of the head word, so the head is visible as soon as the FIFO is non-empty.

## Interface
- B, 8, data word width in bits (≥1)
- W, 4, address bits; depth D = 2**W (W ≥ 1)
- AF_LVL, 2**W-1, almost_full asserts when count ≥ AF_LVL (1..D)
- AE_LVL, 1, almost_empty asserts when count ≤ AE_LVL (0..D-1)

- clk  in  1  rising-edge clock; sole clock
- reset  in  1  synchronous, active-low reset
- clr  in  1  synchronous flush; discards contents, pointers to 0
- wr  in  1  write request
- w_data  in  B  write word
- rd  in  1  read request (pops head)
- r_data  out  B  head word (combinational from array at read pointer)
- empty  out  1  count == 0
- full  out  1  count == D
- almost_empty  out  1  count ≤ AE_LVL
- almost_full  out  1  count ≥ AF_LVL
- count  out  W+1  current occupancy, 0..D
- overflow  out  1  one-cycle pulse: wr while full and no accepted rd
- underflow  out  1  one-cycle pulse: rd while empty

## Operation
- Accept rules, evaluated on registered state each cycle:
  - wr_ok = wr & (~full | rd).
  - rd_ok = rd & ~empty.
- Pointers: W-bit, wrap modulo D.
  - wr_ok: array[w_ptr] ← w_data; w_ptr+1.
  - rd_ok: r_ptr+1.
- Count: count_next = count + wr_ok − rd_ok. Computed at W+1 bits; never exceeds D or goes below 0.
- Flags:
  - empty, full, almost_empty and almost_full are registered.
  - They are computed from count_next, so they are always consistent with count in the same cycle.
- Boundary cases:
  - Empty with wr & rd: write only. count → 1, underflow pulses, r_ptr unchanged.
  - Full with wr & rd: both proceed. count stays D, full stays 1, no overflow.
  - Full with wr only: write dropped, array unchanged, overflow = 1 for one cycle.
  - Empty with rd only: no pointer change, underflow = 1 for one cycle.
- clr:
  - Pointers, count, flags and pulses take their reset values next edge.
  - clr has priority over wr/rd in the same cycle.
  - Array contents are not cleared.
- Reset (reset = 0 at a rising edge), including mid-operation:
  - Pointers 0, count 0.
  - empty = 1, almost_empty = 1, full = 0.
  - almost_full = 0; the AF_LVL ≥ 1 constraint guarantees this.
  - overflow = 0, underflow = 0.
  - Array is not reset; r_data is undefined until the first write.
- No state machine beyond pointer/count registers; the control is a counter-based datapath.

## Timing
- Write-to-visible latency: 1 cycle. A word written at edge n appears on r_data after edge n when it becomes head, with empty = 0 after the same edge.
- Read: r_data is valid combinationally while empty = 0. Asserting rd consumes it at the next edge, and r_data shows the next word after that edge.
- All status outputs change only on rising clk edges.
- overflow and underflow are high for exactly the cycle following the offending request.
- Throughput: one write and one read per cycle sustained.

## Structure
- Shared package fifo_pkg holds:
  - default parameter constants (B, W);
  - the threshold legality rule, checked with an elaboration-time assertion: 1 ≤ AF_LVL ≤ D and 0 ≤ AE_LVL < D.
- Sub-module fifo_regfile: a 2**W × B array with synchronous write port (we, waddr, wdata) and asynchronous read port (raddr, rdata).
- Control logic (pointers, count, flags, pulses) lives in fifo_flagged.

## Test plan
All scenarios use B=8, W=2 (D=4), AF_LVL=3, AE_LVL=1.

1. Reset, then idle:
   - Hold reset=0 for 2 cycles.
   - Required after release: empty=1, almost_empty=1, full=0, almost_full=0, count=0, overflow=0, underflow=0.
2. Fill and overflow:
   - Write 0x11, 0x22, 0x33, 0x44.
   - count steps 1,2,3,4; almost_empty drops at count 2; almost_full rises at count 3; full rises at count 4.
   - Fifth write 0x55 → overflow pulses 1 cycle, count stays 4, and reads then return 0x11..0x44 in order.
3. Drain, underflow and wrap:
   - Push and pop 6 words to wrap the pointers, then read the FIFO to empty and issue one more rd.
   - Required: underflow for 1 cycle, count stays 0, empty=1.
4. Simultaneous rd/wr at the boundaries:
   - At empty, wr=rd=1 with 0xA5 → count=1, r_data=0xA5, underflow pulses.
   - At full, wr=rd=1 with 0x5A → count=4, head advances, 0x5A is read fourth, no overflow.
5. Flush and reset mid-traffic:
   - With count=3, assert clr together with wr → next cycle count=0, empty=1, and the write is dropped.
   - Repeat with reset=0 instead of clr → same result.

Source files
------------

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the flagged FIFO:
//   FIFO_DEF_B / FIFO_DEF_W : default data width and address width
//   fifo_thr_legal()        : threshold legality rule used at elaboration
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_DEF_B = 8;
  localparam int FIFO_DEF_W = 4;

  // almost_full needs 1..D so it can never be set out of reset (count 0);
  // almost_empty needs 0..D-1 so it can never be set while full.
  function automatic bit fifo_thr_legal(input int af_lvl, input int ae_lvl,
                                        input int depth);
    return (af_lvl >= 1) && (af_lvl <= depth) &&
           (ae_lvl >= 0) && (ae_lvl < depth);
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_regfile.sv
// ---------------------------------------------------------------------------
// fifo_regfile
// 2**W x B storage array for the FIFO.
//   clk   : rising-edge clock
//   we    : write enable (synchronous write of wdata at waddr)
//   waddr : write address
//   wdata : write word
//   raddr : read address
//   rdata : read word, combinational from the array at raddr
// Contents are never reset or cleared.
// ---------------------------------------------------------------------------
module fifo_regfile
  import fifo_pkg::*;
#(
  parameter int B = FIFO_DEF_B,
  parameter int W = FIFO_DEF_W
) (
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] waddr,
  input  logic [B-1:0] wdata,
  input  logic [W-1:0] raddr,
  output logic [B-1:0] rdata
);

  localparam int D = 1 << W;

  logic [B-1:0] mem_q [D];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Asynchronous read so the head word is visible as soon as it is written.
  assign rdata = mem_q[raddr];

endmodule : fifo_regfile

// File: rtl/fifo_flagged.sv
// ---------------------------------------------------------------------------
// fifo_flagged
// Synchronous FIFO with occupancy count, almost-full / almost-empty
// thresholds, synchronous flush and overflow / underflow pulses.
//   clk          : rising-edge clock
//   reset        : synchronous, active-low reset
//   clr          : synchronous flush (pointers, count, flags, pulses reset)
//   wr, w_data   : write request and word
//   rd           : read request (pops the head)
//   r_data       : head word, combinational from the array
//   empty/full   : count == 0 / count == D (registered)
//   almost_empty : count <= AE_LVL (registered)
//   almost_full  : count >= AF_LVL (registered)
//   count        : occupancy 0..D
//   overflow     : one-cycle pulse after a write dropped because full
//   underflow    : one-cycle pulse after a read while empty
// ---------------------------------------------------------------------------
module fifo_flagged
  import fifo_pkg::*;
#(
  parameter int B      = FIFO_DEF_B,
  parameter int W      = FIFO_DEF_W,
  parameter int AF_LVL = (1 << W) - 1,
  parameter int AE_LVL = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  input  logic         rd,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full,
  output logic         almost_empty,
  output logic         almost_full,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow
);

  localparam int D = 1 << W;
  localparam logic [W:0] DEPTH_CNT = (W+1)'(D);
  localparam logic [W:0] AF_CNT    = (W+1)'(AF_LVL);
  localparam logic [W:0] AE_CNT    = (W+1)'(AE_LVL);

  if (!fifo_thr_legal(AF_LVL, AE_LVL, D)) begin : g_bad_thresholds
    $error("fifo_flagged: AF_LVL must be 1..D and AE_LVL 0..D-1");
  end

  logic [W-1:0] w_ptr_q, w_ptr_d;
  logic [W-1:0] r_ptr_q, r_ptr_d;
  logic [W:0]   count_q, count_d;
  logic         empty_q, empty_d;
  logic         full_q, full_d;
  logic         almost_empty_q, almost_empty_d;
  logic         almost_full_q, almost_full_d;
  logic         overflow_q, overflow_d;
  logic         underflow_q, underflow_d;

  logic wr_ok;
  logic rd_ok;
  logic mem_we;

  // A write into a full FIFO is allowed when a read frees a slot in the
  // same cycle; a full FIFO is never empty (D >= 2) so that read is accepted.
  assign wr_ok = wr & (~full_q | rd);
  assign rd_ok = rd & ~empty_q;

  // Flush and reset both win over a pending write, so the array is left alone.
  assign mem_we = wr_ok & ~clr & reset;

  always_comb begin
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    count_d     = count_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;

    if (clr) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
      count_d = '0;
    end else begin
      if (wr_ok) begin
        w_ptr_d = w_ptr_q + W'(1);
      end
      if (rd_ok) begin
        r_ptr_d = r_ptr_q + W'(1);
      end
      count_d     = count_q + (W+1)'(wr_ok) - (W+1)'(rd_ok);
      overflow_d  = wr & ~wr_ok;
      underflow_d = rd & empty_q;
    end

    // Flags follow count_d so they line up with count after the edge.
    // With count_d = 0 (clr) these give the reset values.
    empty_d        = (count_d == '0);
    full_d         = (count_d == DEPTH_CNT);
    almost_empty_d = (count_d <= AE_CNT);
    almost_full_d  = (count_d >= AF_CNT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      w_ptr_q        <= '0;
      r_ptr_q        <= '0;
      count_q        <= '0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_empty_q <= 1'b1;
      almost_full_q  <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      w_ptr_q        <= w_ptr_d;
      r_ptr_q        <= r_ptr_d;
      count_q        <= count_d;
      empty_q        <= empty_d;
      full_q         <= full_d;
      almost_empty_q <= almost_empty_d;
      almost_full_q  <= almost_full_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  fifo_regfile #(
    .B (B),
    .W (W)
  ) u_regfile (
    .clk   (clk),
    .we    (mem_we),
    .waddr (w_ptr_q),
    .wdata (w_data),
    .raddr (r_ptr_q),
    .rdata (r_data)
  );

  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = almost_empty_q;
  assign almost_full  = almost_full_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule : fifo_flagged

// File: tb/tb_fifo_flagged.sv
// ---------------------------------------------------------------------------
// tb_fifo_flagged
// Directed bench for fifo_flagged with B=8, W=2 (D=4), AF_LVL=3, AE_LVL=1.
// Expected read words are pushed into a queue as stimulus is issued; a
// monitor on the falling edge pops and compares whenever a read is accepted.
// Status outputs are compared against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_fifo_flagged;

  logic       clk;
  logic       reset;
  logic       clr;
  logic       wr;
  logic [7:0] w_data;
  logic       rd;
  logic [7:0] r_data;
  logic       empty;
  logic       full;
  logic       almost_empty;
  logic       almost_full;
  logic [2:0] count;
  logic       overflow;
  logic       underflow;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];

  fifo_flagged #(
    .B      (8),
    .W      (2),
    .AF_LVL (3),
    .AE_LVL (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clr          (clr),
    .wr           (wr),
    .w_data       (w_data),
    .rd           (rd),
    .r_data       (r_data),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare every status output against hand-computed values.
  task automatic chk_st(input string tag, input int cnt, input int emp,
                        input int ae, input int af, input int ful,
                        input int ov, input int un);
    chk({tag, ".count"}, int'(count), cnt);
    chk({tag, ".empty"}, int'(empty), emp);
    chk({tag, ".almost_empty"}, int'(almost_empty), ae);
    chk({tag, ".almost_full"}, int'(almost_full), af);
    chk({tag, ".full"}, int'(full), ful);
    chk({tag, ".overflow"}, int'(overflow), ov);
    chk({tag, ".underflow"}, int'(underflow), un);
  endtask

  // One clock cycle of stimulus; outputs are settled when this returns.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d,
                     input logic c, input logic rst_n);
    wr = w; rd = r; w_data = d; clr = c; reset = rst_n;
    @(posedge clk);
    #1;
    $display("txn t=%0t wr=%0b rd=%0b d=%02h clr=%0b reset=%0b -> count=%0d r_data=%02h",
             $time, w, r, d, c, rst_n, count, r_data);
    wr = 1'b0; rd = 1'b0; clr = 1'b0; reset = 1'b1;
  endtask

  // Scoreboard monitor: a read is accepted at the coming edge when rd is
  // high and the FIFO is not empty; the head must match the oldest entry.
  initial begin
    forever begin
      @(negedge clk);
      if (rd && !empty && reset && !clr) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL read_unexpected: got 0x%02h expected no read data", r_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (r_data !== e) begin
            errors++;
            $display("FAIL read_data: got 0x%02h expected 0x%02h", r_data, e);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    wr = 1'b0; rd = 1'b0; clr = 1'b0; w_data = 8'h00; reset = 1'b0;

    // 1. Reset held two cycles, then idle.
    cyc(0, 0, 8'h00, 0, 0);
    cyc(0, 0, 8'h00, 0, 0);
    cyc(0, 0, 8'h00, 0, 1);
    chk_st("reset", 0, 1, 1, 0, 0, 0, 0);

    // 2. Fill and overflow.
    cyc(1, 0, 8'h11, 0, 1); exp_q.push_back(8'h11);
    chk_st("fill1", 1, 0, 1, 0, 0, 0, 0);
    chk("fill1.r_data", int'(r_data), 'h11);
    cyc(1, 0, 8'h22, 0, 1); exp_q.push_back(8'h22);
    chk_st("fill2", 2, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 8'h33, 0, 1); exp_q.push_back(8'h33);
    chk_st("fill3", 3, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 8'h44, 0, 1); exp_q.push_back(8'h44);
    chk_st("fill4", 4, 0, 0, 1, 1, 0, 0);
    cyc(1, 0, 8'h55, 0, 1);
    chk_st("overflow", 4, 0, 0, 1, 1, 1, 0);
    cyc(0, 0, 8'h00, 0, 1);
    chk_st("overflow_end", 4, 0, 0, 1, 1, 0, 0);
    cyc(0, 1, 8'h00, 0, 1);
    chk("drain1.count", int'(count), 3);
    cyc(0, 1, 8'h00, 0, 1);
    cyc(0, 1, 8'h00, 0, 1);
    cyc(0, 1, 8'h00, 0, 1);
    chk_st("drained", 0, 1, 1, 0, 0, 0, 0);

    // 3. Push/pop six words to wrap the pointers, then underflow.
    cyc(1, 0, 8'h60, 0, 1); exp_q.push_back(8'h60);
    cyc(1, 0, 8'h61, 0, 1); exp_q.push_back(8'h61);
    cyc(1, 1, 8'h62, 0, 1); exp_q.push_back(8'h62);
    cyc(1, 1, 8'h63, 0, 1); exp_q.push_back(8'h63);
    cyc(1, 1, 8'h64, 0, 1); exp_q.push_back(8'h64);
    cyc(1, 1, 8'h65, 0, 1); exp_q.push_back(8'h65);
    chk_st("wrap_steady", 2, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 8'h00, 0, 1);
    cyc(0, 1, 8'h00, 0, 1);
    chk_st("wrap_empty", 0, 1, 1, 0, 0, 0, 0);
    cyc(0, 1, 8'h00, 0, 1);
    chk_st("underflow", 0, 1, 1, 0, 0, 0, 1);
    cyc(0, 0, 8'h00, 0, 1);
    chk_st("underflow_end", 0, 1, 1, 0, 0, 0, 0);

    // 4. Simultaneous rd/wr at empty and at full.
    cyc(1, 1, 8'hA5, 0, 1); exp_q.push_back(8'hA5);
    chk_st("empty_rw", 1, 0, 1, 0, 0, 0, 1);
    chk("empty_rw.r_data", int'(r_data), 'hA5);
    cyc(1, 0, 8'hB1, 0, 1); exp_q.push_back(8'hB1);
    cyc(1, 0, 8'hB2, 0, 1); exp_q.push_back(8'hB2);
    cyc(1, 0, 8'hB3, 0, 1); exp_q.push_back(8'hB3);
    chk_st("refill", 4, 0, 0, 1, 1, 0, 0);
    cyc(1, 1, 8'h5A, 0, 1); exp_q.push_back(8'h5A);
    chk_st("full_rw", 4, 0, 0, 1, 1, 0, 0);
    chk("full_rw.r_data", int'(r_data), 'hB1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'h00, 0, 1);
    chk_st("full_rw_drained", 0, 1, 1, 0, 0, 0, 0);

    // 5a. Flush with a concurrent write.
    cyc(1, 0, 8'hC1, 0, 1);
    cyc(1, 0, 8'hC2, 0, 1);
    cyc(1, 0, 8'hC3, 0, 1);
    chk("pre_clr.count", int'(count), 3);
    cyc(1, 0, 8'hC4, 1, 1);
    chk_st("clr", 0, 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 8'hD1, 0, 1); exp_q.push_back(8'hD1);
    chk("post_clr.r_data", int'(r_data), 'hD1);
    cyc(0, 1, 8'h00, 0, 1);
    chk("post_clr.count", int'(count), 0);

    // 5b. Same with reset instead of clr.
    cyc(1, 0, 8'hE1, 0, 1);
    cyc(1, 0, 8'hE2, 0, 1);
    cyc(1, 0, 8'hE3, 0, 1);
    chk("pre_rst.count", int'(count), 3);
    cyc(1, 0, 8'hE4, 0, 0);
    chk_st("mid_reset", 0, 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 8'hF1, 0, 1); exp_q.push_back(8'hF1);
    chk("post_rst.r_data", int'(r_data), 'hF1);
    cyc(0, 1, 8'h00, 0, 1);
    chk_st("final", 0, 1, 1, 0, 0, 0, 0);

    cyc(0, 0, 8'h00, 0, 1);
    chk("scoreboard_left", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fifo_flagged
